wb_commit: RTL and testbench

- MEM/WB pipeline register and write-back/commit stage of the 5-stage MIPS core.
- Produces every write-side signal that the decode stage's register file and CP0 consume: wb_data, wb_rf_wen/wnum, wb_cp0_*, except.
- Aligns load data, detects and prioritises exceptions, and commits ERET.
- Drives the pipeline flush and PC redirect.

---
 rtl/wb_commit_pkg.sv | 53 +++++
 rtl/wb_commit_load_align.sv | 32 +++
 rtl/wb_commit.sv | 159 +++++++++++++++
 tb/tb_wb_commit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_commit_pkg.sv
// Shared MIPS core definitions: exception codes, CP0 numbers, byte-enable
// encodings and the MEM/WB register layout used by the write-back stage.
package mips_defs;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    localparam int          STATUS_EXL = 1;
    localparam logic [31:0] EXL_MASK   = 32'h1 << STATUS_EXL;

    typedef enum logic {RUN, SQUASH} wb_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        in_delay_slot;
        logic [31:0] alu_result;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [3:0]  ren;
        logic [3:0]  wen;
        logic        is_unsigned;
        logic        to_reg;
        logic        reg_write;
        logic [4:0]  reg_num;
        logic        cp0_write;
        logic [4:0]  cp0_wnum;
        logic [2:0]  cp0_sel;
        logic        bad_inst;
        logic        epc_inst;
        logic        syscall;
        logic        brk;
        logic        fetch_adel;
    } mem_fields_t;

    // Halfword accesses need an even address, word accesses a 4-byte aligned one.
    function automatic logic misaligned(input logic [3:0] be, input logic [1:0] addr);
        return (be == BE_HALF && addr[0]) || (be == BE_WORD && addr != 2'b00);
    endfunction

endpackage

// File: rtl/wb_commit_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the raw
// memory word and sign- or zero-extends it to 32 bits.
module load_align
    import mips_defs::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [3:0]  ren,
    input  logic        zero_ext,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        case (ren)
            BE_BYTE: data = {{24{byte_sel[7] & ~zero_ext}}, byte_sel};
            BE_HALF: data = {{16{half_sel[15] & ~zero_ext}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_commit.sv
// MEM/WB pipeline register and commit stage: load write-back, exception
// prioritisation, ERET commit, pipeline flush and PC redirect.
module wb_commit
    import mips_defs::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter logic [31:0] RESET_PC   = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write,
    input  logic        flush,
    input  logic [31:0] mem_pc,
    input  logic        mem_in_delay_slot,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic [3:0]  mem_ren,
    input  logic [3:0]  mem_wen,
    input  logic        mem_unsigned,
    input  logic        mem_to_reg,
    input  logic        mem_regWrite,
    input  logic [4:0]  mem_reg_num,
    input  logic        mem_cp0Write,
    input  logic [4:0]  mem_cp0_wnum,
    input  logic [2:0]  mem_cp0_sel,
    input  logic        mem_bad_inst,
    input  logic        mem_epc_inst,
    input  logic        mem_syscall,
    input  logic        mem_break,
    input  logic        mem_fetch_adel,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_epc,
    output logic [31:0] wb_data,
    output logic        wb_rf_wen,
    output logic [4:0]  wb_rf_wnum,
    output logic        wb_cp0_wen,
    output logic [4:0]  wb_cp0_wnum,
    output logic [2:0]  wb_cp0_sel,
    output logic        except,
    output logic [31:0] wb_cp0_state,
    output logic [31:0] wb_cp0_cause,
    output logic [31:0] wb_cp0_badAdddress,
    output logic [31:0] wb_cp0_epc,
    output logic        flush_out,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    mem_fields_t r;
    mem_fields_t in_fields;
    logic        valid;
    wb_state_e   state, state_next;

    logic        exc_hit;
    logic [4:0]  exc_code;
    logic [31:0] exc_bad;
    logic        take_exc, take_eret, commit;
    logic [31:0] load_data;

    assign in_fields = '{
        pc: mem_pc, in_delay_slot: mem_in_delay_slot, alu_result: mem_alu_result,
        addr: mem_addr, rdata: mem_rdata, ren: mem_ren, wen: mem_wen,
        is_unsigned: mem_unsigned, to_reg: mem_to_reg, reg_write: mem_regWrite,
        reg_num: mem_reg_num, cp0_write: mem_cp0Write, cp0_wnum: mem_cp0_wnum,
        cp0_sel: mem_cp0_sel, bad_inst: mem_bad_inst, epc_inst: mem_epc_inst,
        syscall: mem_syscall, brk: mem_break, fetch_adel: mem_fetch_adel
    };

    always_ff @(posedge clk) begin
        if (rst) begin
            r     <= '0;
            valid <= 1'b0;
            state <= RUN;
        end else begin
            state <= state_next;
            if (write)
                r <= in_fields;
            // A commit kills whatever arrives on the following edge, stalled or not.
            if (commit)
                valid <= 1'b0;
            else if (write)
                valid <= !flush && state == RUN;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (commit) state_next = SQUASH;
            SQUASH:  if (write)  state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        exc_hit  = 1'b1;
        exc_code = EXC_INT;
        exc_bad  = '0;
        if (r.fetch_adel) begin
            exc_code = EXC_ADEL;
            exc_bad  = r.pc;
        end else if (r.bad_inst) begin
            exc_code = EXC_RI;
        end else if (r.syscall) begin
            exc_code = EXC_SYS;
        end else if (r.brk) begin
            exc_code = EXC_BP;
        end else if (misaligned(r.ren, r.addr[1:0])) begin
            exc_code = EXC_ADEL;
            exc_bad  = r.addr;
        end else if (misaligned(r.wen, r.addr[1:0])) begin
            exc_code = EXC_ADES;
            exc_bad  = r.addr;
        end else begin
            exc_hit = 1'b0;
        end
    end

    assign take_exc  = valid && state == RUN && exc_hit;
    assign take_eret = valid && state == RUN && !exc_hit && r.epc_inst;
    assign commit    = take_exc || take_eret;

    load_align u_load_align (
        .rdata    (r.rdata),
        .addr     (r.addr[1:0]),
        .ren      (r.ren),
        .zero_ext (r.is_unsigned),
        .data     (load_data)
    );

    always_comb begin
        wb_data            = r.to_reg ? load_data : r.alu_result;
        wb_rf_wen          = valid && r.reg_write && r.reg_num != 5'd0 && !commit;
        wb_rf_wnum         = r.reg_num;
        wb_cp0_wen         = valid && r.cp0_write && !commit;
        wb_cp0_wnum        = r.cp0_wnum;
        wb_cp0_sel         = r.cp0_sel;
        except             = commit;
        flush_out          = commit;
        redirect_valid     = commit;
        redirect_pc        = RESET_PC;
        wb_cp0_state       = '0;
        wb_cp0_cause       = '0;
        wb_cp0_badAdddress = '0;
        wb_cp0_epc         = '0;
        if (take_exc) begin
            redirect_pc        = EXC_VECTOR;
            wb_cp0_state       = cp0_status | EXL_MASK;
            wb_cp0_cause       = {r.in_delay_slot, 24'd0, exc_code, 2'b00};
            wb_cp0_badAdddress = exc_bad;
            wb_cp0_epc         = r.in_delay_slot ? r.pc - 32'd4 : r.pc;
        end else if (take_eret) begin
            redirect_pc  = cp0_epc;
            wb_cp0_state = cp0_status & ~EXL_MASK;
        end
    end

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: load-align vector table, directed
// commit/stall/reset sequences and a randomised run against a reference model.
module tb_wb_commit;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;
    localparam logic [31:0] RESET_PC   = 32'hBFC00000;

    typedef struct packed {
        logic [31:0] pc;
        logic        ds;
        logic [31:0] alu;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [3:0]  ren;
        logic [3:0]  wen;
        logic        uns;
        logic        to_reg;
        logic        regw;
        logic [4:0]  rnum;
        logic        cp0w;
        logic [4:0]  cwnum;
        logic [2:0]  csel;
        logic        bad;
        logic        eret;
        logic        sys;
        logic        brk;
        logic        fadel;
    } mi_t;

    typedef struct {
        logic [3:0]  ren;
        logic [1:0]  lo;
        logic        uns;
        logic        to_reg;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst, write, flush;
    logic [31:0] cp0_status, cp0_epc;
    mi_t cur;

    logic [31:0] wb_data, wb_cp0_state, wb_cp0_cause, wb_cp0_badAdddress, wb_cp0_epc, redirect_pc;
    logic        wb_rf_wen, wb_cp0_wen, except, flush_out, redirect_valid;
    logic [4:0]  wb_rf_wnum, wb_cp0_wnum;
    logic [2:0]  wb_cp0_sel;

    int checks = 0;
    int errors = 0;

    mi_t held;
    bit  live, sq;

    always #5 clk = ~clk;

    wb_commit #(.EXC_VECTOR(EXC_VECTOR), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .write(write), .flush(flush),
        .mem_pc(cur.pc), .mem_in_delay_slot(cur.ds), .mem_alu_result(cur.alu),
        .mem_addr(cur.addr), .mem_rdata(cur.rdata), .mem_ren(cur.ren), .mem_wen(cur.wen),
        .mem_unsigned(cur.uns), .mem_to_reg(cur.to_reg), .mem_regWrite(cur.regw),
        .mem_reg_num(cur.rnum), .mem_cp0Write(cur.cp0w), .mem_cp0_wnum(cur.cwnum),
        .mem_cp0_sel(cur.csel), .mem_bad_inst(cur.bad), .mem_epc_inst(cur.eret),
        .mem_syscall(cur.sys), .mem_break(cur.brk), .mem_fetch_adel(cur.fadel),
        .cp0_status(cp0_status), .cp0_epc(cp0_epc),
        .wb_data(wb_data), .wb_rf_wen(wb_rf_wen), .wb_rf_wnum(wb_rf_wnum),
        .wb_cp0_wen(wb_cp0_wen), .wb_cp0_wnum(wb_cp0_wnum), .wb_cp0_sel(wb_cp0_sel),
        .except(except), .wb_cp0_state(wb_cp0_state), .wb_cp0_cause(wb_cp0_cause),
        .wb_cp0_badAdddress(wb_cp0_badAdddress), .wb_cp0_epc(wb_cp0_epc),
        .flush_out(flush_out), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit misal(input logic [3:0] be, input logic [1:0] a);
        return (be == 4'hF && a != 2'd0) || (be == 4'h3 && a[0]);
    endfunction

    function automatic bit exc_info(input mi_t m, output logic [4:0] code, output logic [31:0] badv);
        code = 5'd0;
        badv = 32'd0;
        if (m.fadel)                      begin code = 5'd4;  badv = m.pc;   return 1'b1; end
        if (m.bad)                        begin code = 5'd10; return 1'b1; end
        if (m.sys)                        begin code = 5'd8;  return 1'b1; end
        if (m.brk)                        begin code = 5'd9;  return 1'b1; end
        if (misal(m.ren, m.addr[1:0]))    begin code = 5'd4;  badv = m.addr; return 1'b1; end
        if (misal(m.wen, m.addr[1:0]))    begin code = 5'd5;  badv = m.addr; return 1'b1; end
        return 1'b0;
    endfunction

    function automatic logic [31:0] aligned(input mi_t m);
        int          width;
        int          shift;
        logic [31:0] raw;
        logic [31:0] keep;
        width = (m.ren == 4'h1) ? 8 : (m.ren == 4'h3) ? 16 : 32;
        shift = (width == 8) ? 8 * int'(m.addr[1:0]) : (width == 16) ? 16 * int'(m.addr[1]) : 0;
        raw   = m.rdata >> shift;
        if (width == 32) return raw;
        keep = (32'd1 << width) - 32'd1;
        raw  = raw & keep;
        if (!m.uns && raw[width-1]) raw = raw | ~keep;
        return raw;
    endfunction

    task automatic model_edge();
        logic [4:0]  c;
        logic [31:0] b;
        if (rst) begin
            held = '0; live = 1'b0; sq = 1'b0;
        end else if (live && (exc_info(held, c, b) || held.eret)) begin
            if (write) held = cur;
            live = 1'b0; sq = 1'b1;
        end else if (write) begin
            held = cur;
            live = !flush && !sq;
            sq   = 1'b0;
        end
    endtask

    task automatic compare_all();
        logic [4:0]  code;
        logic [31:0] badv;
        bit          hit, exc, eret, cm;
        hit  = exc_info(held, code, badv);
        exc  = live && hit;
        eret = live && !hit && held.eret;
        cm   = exc || eret;
        chk("except", except, cm);
        chk("flush_out", flush_out, cm);
        chk("redirect_valid", redirect_valid, cm);
        chk("redirect_pc", redirect_pc, exc ? EXC_VECTOR : eret ? cp0_epc : RESET_PC);
        chk("wb_data", wb_data, held.to_reg ? aligned(held) : held.alu);
        chk("wb_rf_wen", wb_rf_wen, live && held.regw && held.rnum != 0 && !cm);
        chk("wb_rf_wnum", wb_rf_wnum, held.rnum);
        chk("wb_cp0_wen", wb_cp0_wen, live && held.cp0w && !cm);
        chk("wb_cp0_wnum", wb_cp0_wnum, held.cwnum);
        chk("wb_cp0_sel", wb_cp0_sel, held.csel);
        chk("wb_cp0_state", wb_cp0_state, exc ? (cp0_status | 32'h2) : eret ? (cp0_status & ~32'h2) : 32'h0);
        chk("wb_cp0_cause", wb_cp0_cause, exc ? ({held.ds, 31'd0} | (32'(code) << 2)) : 32'h0);
        chk("wb_cp0_badAdddress", wb_cp0_badAdddress, exc ? badv : 32'h0);
        chk("wb_cp0_epc", wb_cp0_epc, exc ? (held.ds ? held.pc - 32'd4 : held.pc) : 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        cur = '0; write = 1'b1; flush = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [3:0] pick_be();
        case ($urandom_range(0, 3))
            0: return 4'h0;
            1: return 4'h1;
            2: return 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    vec_t tbl[9];

    initial begin
        tbl[0] = '{4'h1, 2'd2, 1'b0, 1'b1, 32'h12F45678, 32'h0, 32'hFFFFFFF4};
        tbl[1] = '{4'h1, 2'd2, 1'b1, 1'b1, 32'h12F45678, 32'h0, 32'h000000F4};
        tbl[2] = '{4'h1, 2'd3, 1'b0, 1'b1, 32'h12F45678, 32'h0, 32'h00000012};
        tbl[3] = '{4'h1, 2'd1, 1'b0, 1'b1, 32'h00008000, 32'h0, 32'hFFFFFF80};
        tbl[4] = '{4'h3, 2'd0, 1'b0, 1'b1, 32'h80017FFF, 32'h0, 32'h00007FFF};
        tbl[5] = '{4'h3, 2'd2, 1'b0, 1'b1, 32'h80017FFF, 32'h0, 32'hFFFF8001};
        tbl[6] = '{4'h3, 2'd2, 1'b1, 1'b1, 32'h80017FFF, 32'h0, 32'h00008001};
        tbl[7] = '{4'hF, 2'd0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
        tbl[8] = '{4'h1, 2'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h13572468, 32'h13572468};

        cur = '0; write = 1'b1; flush = 1'b0; rst = 1'b1;
        cp0_status = 32'h0; cp0_epc = 32'h0;
        held = '0; live = 1'b0; sq = 1'b0;

        // reset
        tick();
        chk("rst_except", except, 1'b0);
        chk("rst_redirect_pc", redirect_pc, RESET_PC);
        chk("rst_redirect_valid", redirect_valid, 1'b0);
        chk("rst_wb_data", wb_data, 32'h0);
        rst = 1'b0;

        // load alignment table
        for (int i = 0; i < 9; i++) begin
            cur = '0;
            cur.pc = 32'h100 + 32'(4 * i);
            cur.addr = {30'h400, tbl[i].lo};
            cur.ren = tbl[i].to_reg ? tbl[i].ren : 4'h0;
            cur.uns = tbl[i].uns;
            cur.to_reg = tbl[i].to_reg;
            cur.rdata = tbl[i].rdata;
            cur.alu = tbl[i].alu;
            cur.regw = 1'b1;
            cur.rnum = 5'd5;
            tick();
            chk("tbl_data", wb_data, tbl[i].exp);
            chk("tbl_rf_wen", wb_rf_wen, 1'b1);
        end

        // misaligned word load
        cur = '0; cur.pc = 32'h200; cur.addr = 32'h1002; cur.ren = 4'hF;
        cur.to_reg = 1'b1; cur.regw = 1'b1; cur.rnum = 5'd7;
        tick();
        chk("adel_except", except, 1'b1);
        chk("adel_cause", wb_cp0_cause, 32'h10);
        chk("adel_bad", wb_cp0_badAdddress, 32'h1002);
        chk("adel_redirect", redirect_pc, 32'hBFC00380);
        chk("adel_rf_wen", wb_rf_wen, 1'b0);
        cur = '0; cur.regw = 1'b1; cur.rnum = 5'd3; cur.alu = 32'h55;
        tick();
        chk("adel_after_except", except, 1'b0);
        chk("adel_after_rf_wen", wb_rf_wen, 1'b0);
        tick();
        chk("adel_squash_rf_wen", wb_rf_wen, 1'b0);
        tick();
        chk("adel_resume_rf_wen", wb_rf_wen, 1'b1);

        // RI beats SYSCALL, delay slot
        cp0_status = 32'h0000FF01;
        cur = '0; cur.pc = 32'h400; cur.ds = 1'b1; cur.bad = 1'b1; cur.sys = 1'b1;
        tick();
        chk("ri_cause", wb_cp0_cause, 32'h80000028);
        chk("ri_epc", wb_cp0_epc, 32'h3FC);
        chk("ri_status", wb_cp0_state, 32'h0000FF03);
        idle(2);

        // ERET
        cp0_status = 32'h3; cp0_epc = 32'h80000100;
        cur = '0; cur.pc = 32'h500; cur.eret = 1'b1; cur.regw = 1'b1; cur.rnum = 5'd9;
        tick();
        chk("eret_except", except, 1'b1);
        chk("eret_status", wb_cp0_state, 32'h1);
        chk("eret_redirect", redirect_pc, 32'h80000100);
        chk("eret_rf_wen", wb_rf_wen, 1'b0);
        idle(2);

        // exception while stalled
        cur = '0; cur.pc = 32'h600; cur.sys = 1'b1;
        tick();
        chk("stall_except", except, 1'b1);
        write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_except_low", except, 1'b0);
        end
        cur = '0; cur.regw = 1'b1; cur.rnum = 5'd4; cur.alu = 32'hA5A5;
        write = 1'b1;
        tick();
        chk("stall_squash_rf_wen", wb_rf_wen, 1'b0);
        tick();
        chk("stall_resume_rf_wen", wb_rf_wen, 1'b1);

        // reset together with an exception
        cur = '0; cur.pc = 32'h700; cur.brk = 1'b1; cur.regw = 1'b1; cur.rnum = 5'd2;
        rst = 1'b1;
        tick();
        chk("rstx_except", except, 1'b0);
        chk("rstx_redirect_pc", redirect_pc, RESET_PC);
        chk("rstx_cause", wb_cp0_cause, 32'h0);
        chk("rstx_rf_wnum", wb_rf_wnum, 5'd0);
        rst = 1'b0;

        // randomised run
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 49) == 0);
            write = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 7) == 0);
            cp0_status = $urandom;
            cp0_epc    = $urandom;
            cur = '0;
            cur.pc     = $urandom & 32'hFFFFFFFC;
            cur.ds     = ($urandom_range(0, 3) == 0);
            cur.alu    = $urandom;
            cur.addr   = $urandom;
            cur.rdata  = $urandom;
            cur.ren    = pick_be();
            cur.wen    = (cur.ren == 4'h0 && $urandom_range(0, 2) == 0) ? pick_be() : 4'h0;
            cur.uns    = 1'($urandom);
            cur.to_reg = (cur.ren != 4'h0);
            cur.regw   = ($urandom_range(0, 3) != 0);
            cur.rnum   = 5'($urandom);
            cur.cp0w   = ($urandom_range(0, 7) == 0);
            cur.cwnum  = 5'($urandom);
            cur.csel   = 3'($urandom);
            cur.bad    = ($urandom_range(0, 15) == 0);
            cur.eret   = ($urandom_range(0, 11) == 0);
            cur.sys    = ($urandom_range(0, 15) == 0);
            cur.brk    = ($urandom_range(0, 15) == 0);
            cur.fadel  = ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
